// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA pipeline: default 640x480@60 mode,
// derived totals and sync windows, and the RGB332 pixel layout that
// vga_data_in packs its colour bytes with.
package vga_timing_pkg;

    // Raster counters are 10 bits, so a mode may span at most 1024 clocks/lines.
    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    // Default mode: 640x480@60 on a 25 MHz pixel clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync windows are inclusive: [start, end].
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // RGB332 byte layout shared with vga_data_in.
    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Inclusive window test on a raster counter.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that delays the sync pair so it lines up
// with the pixel source's registered colour output. DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage;

        // Shift one stage per enabled clock; the whole chain holds while en=0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: each stage is a real flop in a short chain, not RAM, so all of
                // them are reset; otherwise a stale sync level would leak out after reset.
                for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else if (en) begin
                // NOTE: non-blocking assignment makes every stage read its neighbour's
                // old value, which is what makes this a shift rather than a single copy.
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: horizontal/vertical counters, the registered
// pixel-coordinate interface (X, Y, valid, line/frame pulses) and sync
// outputs delayed to match the pixel source latency.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   LATENCY  = 1
) (
    input  logic             VGA_CLK,
    input  logic             RST_N,      // active-high despite the name
    input  logic             EN,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             valid,
    output logic             line_start,
    output logic             frame_start,
    output logic             VGA_HS,
    output logic             VGA_VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject modes the 10-bit counters cannot represent, and unsupported delays.
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
        $error("vga_sync_gen: LATENCY must be 0..4");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             visible;
    logic             hs_raw;
    logic             vs_raw;
    logic             hs_q;
    logic             vs_q;

    assign visible = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hs_raw  = in_window(hcnt, H_SS, H_SE);
    assign vs_raw  = in_window(vcnt, V_SS, V_SE);

    // Raster position: hcnt wraps every line, vcnt steps on each hcnt wrap.
    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (EN) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Register the coordinate interface and raw sync one cycle behind the counters.
    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            X           <= '0;
            Y           <= '0;
            valid       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
        end else if (EN) begin
            X           <= visible ? hcnt : '0;
            Y           <= visible ? vcnt : '0;
            valid       <= visible;
            line_start  <= visible && (hcnt == '0);
            frame_start <= visible && (hcnt == '0) && (vcnt == '0);
            hs_q        <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vs_q        <= vs_raw ? SYNC_POL : ~SYNC_POL;
        end
    end

    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (LATENCY),
        .RESET_VAL ({2{~SYNC_POL}})
    ) u_sync_dly (
        .clk (VGA_CLK),
        .rst (RST_N),
        .en  (EN),
        .d   ({hs_q, vs_q}),
        .q   ({VGA_HS, VGA_VS})
    );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen. Four instances share clock, enable and
// reset: the default 640x480 mode with two latency/polarity settings, and a
// tiny mode that wraps whole frames many times. The reference model derives
// every expected output from one number: the count of enabled clock edges
// since reset.
module tb_vga_sync_gen;

    localparam int NI = 4;
    localparam int HA  [NI] = '{640, 640, 16, 16};
    localparam int HFP [NI] = '{16,  16,  3,  3};
    localparam int HSW [NI] = '{96,  96,  4,  4};
    localparam int HBP [NI] = '{48,  48,  2,  2};
    localparam int VA  [NI] = '{480, 480, 6,  6};
    localparam int VFP [NI] = '{10,  10,  2,  2};
    localparam int VSW [NI] = '{2,   2,   3,  3};
    localparam int VBP [NI] = '{33,  33,  2,  2};
    localparam int LAT [NI] = '{1,   3,   0,  4};
    localparam logic POL [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct packed {
        logic [63:0]       t;
        exp_t [NI-1:0]     e;
    } entry_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] x_o     [NI];
    logic [9:0] y_o     [NI];
    logic       valid_o [NI];
    logic       ls_o    [NI];
    logic       fs_o    [NI];
    logic       hs_o    [NI];
    logic       vs_o    [NI];

    entry_t sb[$];
    longint k;
    int     n_checks;
    int     n_errors;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_sync_gen #(
            .H_ACTIVE (HA[g]),  .H_FP (HFP[g]), .H_SYNC (HSW[g]), .H_BP (HBP[g]),
            .V_ACTIVE (VA[g]),  .V_FP (VFP[g]), .V_SYNC (VSW[g]), .V_BP (VBP[g]),
            .SYNC_POL (POL[g]), .LATENCY (LAT[g])
        ) u_dut (
            .VGA_CLK     (clk),
            .RST_N       (rst),
            .EN          (en),
            .X           (x_o[g]),
            .Y           (y_o[g]),
            .valid       (valid_o[g]),
            .line_start  (ls_o[g]),
            .frame_start (fs_o[g]),
            .VGA_HS      (hs_o[g]),
            .VGA_VS      (vs_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n enabled edges: outputs describe raster position
    // n-1; the syncs describe position n-1-LATENCY (idle level if not yet reached).
    function automatic exp_t model(input int g, input longint n);
        exp_t   r;
        longint p;
        longint q;
        int     ht, vt, h, v, hq, vq;
        ht = HA[g] + HFP[g] + HSW[g] + HBP[g];
        vt = VA[g] + VFP[g] + VSW[g] + VBP[g];
        r = '0;
        r.hs = ~POL[g];
        r.vs = ~POL[g];
        if (n > 0) begin
            p = n - 1;
            h = int'(p % ht);
            v = int'((p / ht) % vt);
            r.valid = (h < HA[g]) && (v < VA[g]);
            if (r.valid) begin
                r.x = 10'(h);
                r.y = 10'(v);
            end
            r.ls = r.valid && (h == 0);
            r.fs = r.ls && (v == 0);
            q = p - LAT[g];
            if (q >= 0) begin
                hq = int'(q % ht);
                vq = int'((q / ht) % vt);
                if (hq >= HA[g] + HFP[g] && hq < HA[g] + HFP[g] + HSW[g]) r.hs = POL[g];
                if (vq >= VA[g] + VFP[g] && vq < VA[g] + VFP[g] + VSW[g]) r.vs = POL[g];
            end
        end
        return r;
    endfunction

    task automatic push(input logic [63:0] t);
        entry_t ent;
        ent.t = t;
        for (int g = 0; g < NI; g++) ent.e[g] = model(g, k);
        sb.push_back(ent);
    endtask

    task automatic check(input string name, input int g, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, g, $time, act, exp);
        end
    endtask

    // One clock: apply enable, account for the edge in the model, queue the
    // expectation for the following falling edge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        if (rst) k = 0;
        else if (en) k++;
        push($time + 5);
        @(negedge clk);
    endtask

    // Monitor: compare each queued expectation once its sample time arrives.
    initial begin
        entry_t cur;
        forever begin
            if (sb.size() == 0 || sb[0].t > $time) begin
                #1;
            end else begin
                cur = sb.pop_front();
                for (int g = 0; g < NI; g++) begin
                    check("X",           g, x_o[g],            cur.e[g].x);
                    check("Y",           g, y_o[g],            cur.e[g].y);
                    check("valid",       g, {9'd0, valid_o[g]}, {9'd0, cur.e[g].valid});
                    check("line_start",  g, {9'd0, ls_o[g]},    {9'd0, cur.e[g].ls});
                    check("frame_start", g, {9'd0, fs_o[g]},    {9'd0, cur.e[g].fs});
                    check("VGA_HS",      g, {9'd0, hs_o[g]},    {9'd0, cur.e[g].hs});
                    check("VGA_VS",      g, {9'd0, vs_o[g]},    {9'd0, cur.e[g].vs});
                end
            end
        end
    end

    localparam longint FREEZE_AT = 50 * 800 + 100 + 1;   // dut0 shows X=100, Y=50
    localparam longint RESET_AT  = 52 * 800 + 300 + 1;   // dut0 shows X=300, Y=52

    initial begin
        int cycles;
        n_checks = 0;
        n_errors = 0;
        k   = 0;
        rst = 1'b1;
        en  = 1'b1;

        // Reset held for 5 cycles, then free run with random enable gaps.
        repeat (5) step(1'b1);
        rst = 1'b0;
        cycles = 0;
        while (k != FREEZE_AT && cycles < 60000) begin
            step($urandom_range(0, 15) != 0);
            cycles++;
        end
        check("reach_freeze_point", 0, {9'd0, k == FREEZE_AT}, 10'd1);

        // Hold the raster for 37 cycles, then resume.
        repeat (37) step(1'b0);
        cycles = 0;
        while (k != RESET_AT && cycles < 5000) begin
            step(1'b1);
            cycles++;
        end
        check("reach_reset_point", 0, {9'd0, k == RESET_AT}, 10'd1);

        // Asynchronous reset pulse between clock edges, checked before the next edge.
        #2;
        rst = 1'b1;
        k   = 0;
        push($time + 1);
        step(1'b1);
        rst = 1'b0;

        repeat (3000) step($urandom_range(0, 7) != 0);
        repeat (1000) step(1'b1);

        #20;
        check("scoreboard_drained", 0, 10'(sb.size()), 10'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
